iqueue: RTL and testbench

- Instruction queue between the fetch frontend and the out-of-order backend.
- Buffers fetched {pc, inst, predicted-target} entries in program order.
- Presents the head entry first-word-fall-through on the backend read port (iqueue_ren/iqueue_rdata/iqueue_empty) consumed by rename.
- Flushed in one cycle on a branch redirect.

---
 rtl/iqueue_pkg.sv | 14 +
 rtl/iqueue_ptr.sv | 23 ++
 rtl/iqueue.sv | 86 ++++++++
 tb/tb_iqueue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/iqueue_pkg.sv
// Shared instruction-queue types and default sizing, used by fetch, rename and the queue itself.
package iqueue_pkg;

  localparam int IQUEUE_DEPTH      = 16;
  localparam int IQUEUE_ADDR_WIDTH = $clog2(IQUEUE_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
  } iqueue_t;

endpackage

// File: rtl/iqueue_ptr.sv
// Queue pointer carrying one wrap bit above the index; load (flush) wins over increment.
module iqueue_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (inc) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/iqueue.sv
// In-order instruction queue between fetch and rename: first-word-fall-through head,
// single-cycle flush on redirect, sticky overflow/underflow diagnostics.
module iqueue
  import iqueue_pkg::*;
#(
  parameter int IQUEUE_DEPTH      = iqueue_pkg::IQUEUE_DEPTH,
  parameter int IQUEUE_ADDR_WIDTH = $clog2(IQUEUE_DEPTH),
  parameter int AFULL_SLACK       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         iqueue_wen,
  input  iqueue_t                      iqueue_wdata,
  output logic                         iqueue_full,
  output logic                         iqueue_almost_full,
  input  logic                         iqueue_ren,
  output iqueue_t                      iqueue_rdata,
  output logic                         iqueue_empty,
  output logic [IQUEUE_ADDR_WIDTH:0]   iqueue_count,
  output logic                         iqueue_overflow,
  output logic                         iqueue_underflow
);

  localparam int PW = IQUEUE_ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_LEVEL = PW'(IQUEUE_DEPTH - AFULL_SLACK);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          write_ok;
  logic          read_ok;

  iqueue_t mem [IQUEUE_DEPTH];

  // Flags decode from registered pointers only; ren never relieves full in the same cycle.
  assign iqueue_empty       = (wptr == rptr);
  assign iqueue_full        = (wptr[IQUEUE_ADDR_WIDTH-1:0] == rptr[IQUEUE_ADDR_WIDTH-1:0]) &&
                              (wptr[IQUEUE_ADDR_WIDTH] != rptr[IQUEUE_ADDR_WIDTH]);
  assign iqueue_count       = wptr - rptr;
  assign iqueue_almost_full = (iqueue_count >= AFULL_LEVEL);

  assign write_ok = iqueue_wen && !iqueue_full && !flush;
  assign read_ok  = iqueue_ren && !iqueue_empty && !flush;

  iqueue_ptr #(.W(PW)) u_wptr (
    .clk        (clk),
    .rst        (rst),
    .inc        (write_ok),
    .load       (1'b0),
    .load_value ('0),
    .value      (wptr)
  );

  // Flush discards everything by pulling the read pointer up to the write pointer.
  iqueue_ptr #(.W(PW)) u_rptr (
    .clk        (clk),
    .rst        (rst),
    .inc        (read_ok),
    .load       (flush),
    .load_value (wptr),
    .value      (rptr)
  );

  always_ff @(posedge clk) begin
    if (write_ok) begin
      mem[wptr[IQUEUE_ADDR_WIDTH-1:0]] <= iqueue_wdata;
    end
  end

  assign iqueue_rdata = iqueue_empty ? iqueue_t'('0) : mem[rptr[IQUEUE_ADDR_WIDTH-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iqueue_overflow  <= 1'b0;
      iqueue_underflow <= 1'b0;
    end else if (!flush) begin
      if (iqueue_wen && iqueue_full) begin
        iqueue_overflow <= 1'b1;
      end
      if (iqueue_ren && iqueue_empty) begin
        iqueue_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iqueue.sv
// Self-checking bench for iqueue: table-driven vectors, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_iqueue;
  import iqueue_pkg::*;

  localparam int D  = 8;
  localparam int AW = $clog2(D);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            wen = 1'b0;
  logic            ren = 1'b0;
  iqueue_t         wdata = '0;
  iqueue_t         rdata;
  logic            full, almost_full, empty, overflow, underflow;
  logic [AW:0]     count;

  int n_checks = 0;
  int n_fail   = 0;

  iqueue_t mq[$];
  logic    m_ovf = 1'b0;
  logic    m_unf = 1'b0;

  typedef struct {
    logic        flush;
    logic        wen;
    logic        ren;
    logic [31:0] pc;
    int          exp_count;
    logic        exp_empty;
    logic        exp_full;
    logic        exp_afull;
    logic [31:0] exp_head_pc;
  } vec_t;

  vec_t vt[$];

  always #5 clk = ~clk;

  iqueue #(.IQUEUE_DEPTH(D), .AFULL_SLACK(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .iqueue_wen         (wen),
    .iqueue_wdata       (wdata),
    .iqueue_full        (full),
    .iqueue_almost_full (almost_full),
    .iqueue_ren         (ren),
    .iqueue_rdata       (rdata),
    .iqueue_empty       (empty),
    .iqueue_count       (count),
    .iqueue_overflow    (overflow),
    .iqueue_underflow   (underflow)
  );

  function automatic iqueue_t mk(input logic [31:0] pc);
    iqueue_t e;
    e.pc          = pc;
    e.inst        = ~pc;
    e.pred_taken  = pc[2];
    e.pred_target = pc + 32'h40;
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    iqueue_t head;
    head = (mq.size() != 0) ? mq[0] : iqueue_t'('0);
    check("empty", 128'(empty), 128'(mq.size() == 0));
    check("full", 128'(full), 128'(mq.size() == D));
    check("almost_full", 128'(almost_full), 128'(mq.size() >= D - 2));
    check("count", 128'(count), 128'(mq.size()));
    check("rdata", 128'(rdata), 128'(head));
    check("overflow", 128'(overflow), 128'(m_ovf));
    check("underflow", 128'(underflow), 128'(m_unf));
  endtask

  // One clock of stimulus; the model applies the queue rules to its pre-edge occupancy.
  task automatic step(input logic f, input logic w, input logic r, input iqueue_t d);
    int sz;
    sz    = mq.size();
    flush = f; wen = w; ren = r; wdata = d;
    if (f) begin
      mq.delete();
    end else begin
      if (r && sz == 0) m_unf = 1'b1;
      if (w && sz == D) m_ovf = 1'b1;
      if (r && sz != 0) void'(mq.pop_front());
      if (w && sz != D) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    flush = 1'b0; wen = 1'b0; ren = 1'b0;
    check_model();
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic add_vec(input logic f, input logic w, input logic r, input logic [31:0] pc,
                         input int c, input logic e, input logic fu, input logic af,
                         input logic [31:0] hp);
    vec_t v;
    v.flush = f; v.wen = w; v.ren = r; v.pc = pc;
    v.exp_count = c; v.exp_empty = e; v.exp_full = fu; v.exp_afull = af; v.exp_head_pc = hp;
    vt.push_back(v);
  endtask

  initial begin
    // Vector table: single write/read, fill to full with overflow, drain in order.
    add_vec(0, 1, 0, 32'h1eceb000, 1, 0, 0, 0, 32'h1eceb000);
    add_vec(0, 0, 1, 32'h0,        0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 8; i++)
      add_vec(0, 1, 0, 32'(i * 4), i + 1, 0, (i == 7), (i >= 5), 32'h0);
    add_vec(0, 1, 0, 32'h20, 8, 0, 1, 1, 32'h0);
    for (int i = 1; i <= 8; i++)
      add_vec(0, 0, 1, 32'h0, 8 - i, (i == 8), 0, (8 - i >= 6), (i == 8) ? 32'h0 : 32'(i * 4));

    #2;
    check("reset_empty", 128'(empty), 128'(1));
    check("reset_full", 128'(full), 128'(0));
    check("reset_afull", 128'(almost_full), 128'(0));
    check("reset_count", 128'(count), 128'(0));
    check("reset_rdata", 128'(rdata), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_model();

    foreach (vt[i]) begin
      step(vt[i].flush, vt[i].wen, vt[i].ren, mk(vt[i].pc));
      check($sformatf("vec%0d_count", i), 128'(count), 128'(vt[i].exp_count));
      check($sformatf("vec%0d_empty", i), 128'(empty), 128'(vt[i].exp_empty));
      check($sformatf("vec%0d_full", i), 128'(full), 128'(vt[i].exp_full));
      check($sformatf("vec%0d_afull", i), 128'(almost_full), 128'(vt[i].exp_afull));
      check($sformatf("vec%0d_head", i), 128'(rdata.pc), 128'(vt[i].exp_head_pc));
    end
    check("tbl_overflow", 128'(overflow), 128'(1));
    check("tbl_underflow", 128'(underflow), 128'(0));

    // Steady read+write at count 3: occupancy and flags hold while pointers wrap.
    for (int i = 0; i < 3; i++) step(0, 1, 0, mk(32'h100 + 32'(i * 4)));
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, mk(32'h200 + 32'(i * 4)));
      check("steady_count", 128'(count), 128'(3));
    end

    // Flush at count 5 with a concurrent write: the write must vanish.
    while (mq.size() < 5) step(0, 1, 0, mk(32'h300 + 32'(mq.size())));
    step(1, 1, 0, mk(32'hdead0000));
    check("flush_empty", 128'(empty), 128'(1));
    check("flush_count", 128'(count), 128'(0));
    step(0, 1, 0, mk(32'h400));
    step(0, 0, 1, mk(32'h0));
    check("flush_next_empty", 128'(empty), 128'(1));

    // Underflow is sticky across flush, cleared only by an async reset pulse.
    step(0, 0, 1, mk(32'h0));
    check("underflow_set", 128'(underflow), 128'(1));
    step(1, 0, 0, mk(32'h0));
    check("underflow_after_flush", 128'(underflow), 128'(1));
    step(0, 1, 0, mk(32'h500));
    #3 rst = 1'b1;
    #1;
    check("async_rst_underflow", 128'(underflow), 128'(0));
    check("async_rst_count", 128'(count), 128'(0));
    check("async_rst_empty", 128'(empty), 128'(1));
    #1 rst = 1'b0;
    model_reset();

    // Full with read+write: head pops, write dropped, overflow set.
    for (int i = 0; i < D; i++) step(0, 1, 0, mk(32'h600 + 32'(i * 4)));
    step(0, 1, 1, mk(32'h6ff0));
    check("full_rw_count", 128'(count), 128'(7));
    check("full_rw_overflow", 128'(overflow), 128'(1));
    check("full_rw_head", 128'(rdata.pc), 128'(32'h604));

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      iqueue_t d;
      d.pc          = $urandom;
      d.inst        = $urandom;
      d.pred_taken  = 1'($urandom);
      d.pred_target = $urandom;
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 9) < 5), d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
